// File: rtl/ascon_ctrl_fsm.sv
// Sequencing controller for the Ascon-128 round stage: walks init, AD, plaintext and
// finalisation, driving round index, XOR selects, input mux and register enable per cycle.
module ascon_ctrl_fsm #(
   parameter int ROUNDS_A = 12,
   parameter int ROUNDS_B = 6,
   parameter int CNT_W    = 4
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [CNT_W-1:0] nb_ad_i,
   input  logic [CNT_W-1:0] nb_pt_i,
   input  logic             data_valid_i,
   output logic             data_req_o,
   output logic [3:0]       round_o,
   output logic             input_sel_o,
   output logic             xorup_sel_o,
   output logic [1:0]       xordn_sel_o,
   output logic             ena_reg_o,
   output logic             cipher_valid_o,
   output logic             tag_valid_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             error_o
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_INIT    = 3'd1,
      S_AD_WAIT = 3'd2,
      S_AD      = 3'd3,
      S_PT_WAIT = 3'd4,
      S_PT      = 3'd5,
      S_FINAL   = 3'd6
   } state_t;

   // p^b runs the last ROUNDS_B round constants; its first round is taken in the WAIT cycle.
   localparam logic [3:0]       RC_LAST = 4'(ROUNDS_A - 1);
   localparam logic [3:0]       RC_B0   = 4'(ROUNDS_A - ROUNDS_B);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

   state_t           state, state_nxt;
   logic [3:0]       rc, rc_nxt;
   logic [CNT_W-1:0] ad_cnt, ad_cnt_nxt;
   logic [CNT_W-1:0] pt_cnt, pt_cnt_nxt;
   logic             done_r, done_nxt;
   logic             error_r, error_nxt;

   // State, round counter, block counters and the two pulse flags.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state   <= S_IDLE;
         rc      <= 4'd0;
         ad_cnt  <= '0;
         pt_cnt  <= '0;
         done_r  <= 1'b0;
         error_r <= 1'b0;
      end else begin
         state   <= state_nxt;
         rc      <= rc_nxt;
         ad_cnt  <= ad_cnt_nxt;
         pt_cnt  <= pt_cnt_nxt;
         done_r  <= done_nxt;
         error_r <= error_nxt;
      end
   end

   // Next-state logic and Mealy decode of the datapath controls.
   always_comb begin
      state_nxt      = state;
      rc_nxt         = rc;
      ad_cnt_nxt     = ad_cnt;
      pt_cnt_nxt     = pt_cnt;
      done_nxt       = 1'b0;
      error_nxt      = 1'b0;
      data_req_o     = 1'b0;
      round_o        = 4'd0;
      input_sel_o    = 1'b0;
      xorup_sel_o    = 1'b0;
      xordn_sel_o    = 2'b00;
      ena_reg_o      = 1'b0;
      cipher_valid_o = 1'b0;
      tag_valid_o    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_i) begin
               if ((nb_ad_i != '0) && (nb_pt_i >= CNT_TWO)) begin
                  ad_cnt_nxt = nb_ad_i;
                  pt_cnt_nxt = nb_pt_i;
                  rc_nxt     = 4'd0;
                  state_nxt  = S_INIT;
               end else begin
                  error_nxt = 1'b1;
               end
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_INIT: begin
            round_o     = rc;
            ena_reg_o   = 1'b1;
            input_sel_o = (rc != 4'd0);
            if (rc == RC_LAST) begin
               xordn_sel_o = 2'b01;
               rc_nxt      = 4'd0;
               state_nxt   = S_AD_WAIT;
            end else begin
               rc_nxt = rc + 4'd1;
            end
         end
         S_AD_WAIT: begin
            data_req_o = 1'b1;
            if (data_valid_i) begin
               round_o     = RC_B0;
               xorup_sel_o = 1'b1;
               input_sel_o = 1'b1;
               ena_reg_o   = 1'b1;
               rc_nxt      = RC_B0 + 4'd1;
               state_nxt   = S_AD;
            end else begin
               state_nxt = S_AD_WAIT;
            end
         end
         S_AD: begin
            round_o     = rc;
            input_sel_o = 1'b1;
            ena_reg_o   = 1'b1;
            if (rc == RC_LAST) begin
               ad_cnt_nxt = ad_cnt - CNT_ONE;
               rc_nxt     = 4'd0;
               if (ad_cnt == CNT_ONE) begin
                  xordn_sel_o = 2'b10;
                  state_nxt   = S_PT_WAIT;
               end else begin
                  state_nxt = S_AD_WAIT;
               end
            end else begin
               rc_nxt = rc + 4'd1;
            end
         end
         S_PT_WAIT: begin
            data_req_o = 1'b1;
            if (data_valid_i) begin
               xorup_sel_o    = 1'b1;
               input_sel_o    = 1'b1;
               ena_reg_o      = 1'b1;
               cipher_valid_o = 1'b1;
               // The last plaintext block absorbs into round 0 of the finalisation p^a.
               if (pt_cnt == CNT_ONE) begin
                  round_o   = 4'd0;
                  rc_nxt    = 4'd1;
                  state_nxt = S_FINAL;
               end else begin
                  round_o   = RC_B0;
                  rc_nxt    = RC_B0 + 4'd1;
                  state_nxt = S_PT;
               end
            end else begin
               state_nxt = S_PT_WAIT;
            end
         end
         S_PT: begin
            round_o     = rc;
            input_sel_o = 1'b1;
            ena_reg_o   = 1'b1;
            if (rc == RC_LAST) begin
               pt_cnt_nxt = pt_cnt - CNT_ONE;
               rc_nxt     = 4'd0;
               if (pt_cnt == CNT_TWO) begin
                  xordn_sel_o = 2'b11;
               end else begin
                  xordn_sel_o = 2'b00;
               end
               state_nxt = S_PT_WAIT;
            end else begin
               rc_nxt = rc + 4'd1;
            end
         end
         S_FINAL: begin
            round_o     = rc;
            input_sel_o = 1'b1;
            ena_reg_o   = 1'b1;
            if (rc == RC_LAST) begin
               xordn_sel_o = 2'b01;
               tag_valid_o = 1'b1;
               done_nxt    = 1'b1;
               rc_nxt      = 4'd0;
               state_nxt   = S_IDLE;
            end else begin
               rc_nxt = rc + 4'd1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            rc_nxt    = 4'd0;
         end
      endcase
   end

   assign busy_o  = (state != S_IDLE);
   assign done_o  = done_r;
   assign error_o = error_r;

endmodule

// File: doc/ascon_ctrl_fsm.md
Name: ascon_ctrl_fsm

Overview:
- Sequencing controller for the Ascon-128 encryption datapath: the permutation round stage with upstream and downstream XOR injection and an enable-gated state register.
- Drives every control input of that stage: round index, upstream and downstream XOR selects, input-mux select and register write enable.
- Runs per-block data handshakes and flags when the stage's cipher and tag outputs are valid.
- Sits directly upstream of the datapath, one instance per datapath.

Parameters:
- ROUNDS_A, 12, rounds of p^a (initialisation and finalisation).
- ROUNDS_B, 6, rounds of p^b (AD and plaintext blocks).
- CNT_W, 4, width of the block counters.

Ports:
- clock_i  in  1  system clock; all state updates on the rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  start request, sampled only in IDLE.
- nb_ad_i  in  CNT_W  number of 64-bit AD blocks, sampled on accepted start.
- nb_pt_i  in  CNT_W  number of 64-bit plaintext blocks, sampled on accepted start.
- data_valid_i  in  1  upstream asserts that the 64-bit block on the datapath's data64_i is valid.
- data_req_o  out  1  controller is ready to consume a block.
- round_o  out  4  round index to the constant adder.
- input_sel_o  out  1  0 = load the external state (IV||K||N), 1 = feed back the register.
- xorup_sel_o  out  1  XOR data64 into x0 before the round.
- xordn_sel_o  out  2  downstream XOR select: 00 none, 01 K into x3||x4, 10 1 into LSB of x4, 11 K into x1||x2.
- ena_reg_o  out  1  state register write enable.
- cipher_valid_o  out  1  datapath cipher_o is valid this cycle.
- tag_valid_o  out  1  datapath tag_o is valid this cycle.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle registered pulse after the tag cycle.
- error_o  out  1  one-cycle registered pulse on a rejected start.

Behaviour:
- Reset (asynchronous, any state): state <- IDLE, counters <- 0, done_o = 0, error_o = 0. All outputs decode to 0.
- Outputs are Mealy-decoded from state, round counter and data_valid_i. One permutation round executes per cycle in which ena_reg_o = 1. In every cycle not listed below, all control outputs are 0.
- IDLE:
  - start_i with nb_ad_i >= 1 and nb_pt_i >= 2: latch both counts, go to INIT with rc = 0.
  - Otherwise a start pulses error_o the next cycle and the FSM stays in IDLE.
  - nb_pt_i >= 2 is mandatory because the domain-separation XOR and the x1||x2 key XOR must use different rounds.
- INIT, rc = 0..11:
  - round_o = rc, ena_reg_o = 1.
  - input_sel_o = 0 only when rc = 0, else 1. The external state must be held valid during rc = 0.
  - At rc = 11: xordn_sel_o = 01, go to AD_WAIT.
- AD_WAIT:
  - data_req_o = 1.
  - On data_valid_i: same cycle round_o = 6, xorup_sel_o = 1, input_sel_o = 1, ena_reg_o = 1. Go to AD with rc = 7.
  - Without data_valid_i: ena_reg_o = 0, register holds indefinitely.
- AD, rc = 7..11:
  - round_o = rc, input_sel_o = 1, ena_reg_o = 1.
  - At rc = 11: decrement ad_cnt.
  - If that was the last AD block: xordn_sel_o = 10, go to PT_WAIT. Else go to AD_WAIT.
- PT_WAIT:
  - data_req_o = 1.
  - On data_valid_i: xorup_sel_o = 1, input_sel_o = 1, ena_reg_o = 1, cipher_valid_o = 1.
  - If pt_cnt = 1 (last block): round_o = 0, go to FINAL with rc = 1. Else round_o = 6, go to PT with rc = 7.
- PT, rc = 7..11:
  - round_o = rc, ena_reg_o = 1.
  - At rc = 11: decrement pt_cnt.
  - If the remaining count is then 1: xordn_sel_o = 11. Go to PT_WAIT.
- FINAL, rc = 1..11:
  - round_o = rc, ena_reg_o = 1.
  - At rc = 11: xordn_sel_o = 01, tag_valid_o = 1, go to IDLE. done_o pulses the following cycle.
- Total cycles with zero wait: 12 + 6*nb_ad + 6*(nb_pt-1) + 12.
- start_i outside IDLE is ignored. data_valid_i outside the WAIT states is ignored and no data is consumed.
- Reset mid-block: the FSM aborts to IDLE. No tag_valid_o and no done_o are produced for the aborted operation.

Test Plan:
- nb_ad = 1, nb_pt = 2, data_valid_i held 1 → 36 enabled cycles; round_o sequence 0..11, 6..11, 6..11, 0..11; xordn_sel_o = 01/10/11/01 at cycles 12/18/24/36; tag_valid_o at cycle 36, done_o at cycle 37.
- Full Ascon-128 known-answer vector (K, N, 1 AD block, 2 PT blocks) through the datapath → cipher_o and tag_o match the reference model bit-exactly.
- start with nb_pt = 1 → error_o = 1 for one cycle, busy_o stays 0; start with nb_ad = 0 → same.
- data_valid_i low for 5 cycles in AD_WAIT → data_req_o = 1 and ena_reg_o = 0 for 5 cycles; datapath state unchanged; sequence resumes at round_o = 6.
- reset_i asserted at FINAL rc = 5 → all outputs 0 immediately, busy_o = 0, no tag_valid_o or done_o; a new start then runs normally.
- nb_ad = 3, nb_pt = 4 → exactly 3 AD and 4 PT handshakes; 4 cipher_valid_o pulses; xordn_sel_o = 11 only after the third PT block.
